// File: rtl/spec_frame_sequencer_pkg.sv
// Shared constants and the sequencer state type for the FFT power-spectrum frame sequencer.
// Contents:
//   FftN / Log2N / HalfN  FFT frame geometry (bins returned per frame = HalfN)
//   GateW / PulseW        gate and pulse counter/config widths
//   FifoCw                sample FIFO occupancy width
//   AddrW                 accumulator address width {gate, bin}
//   FramesW               frames-in-flight counter width
//   seq_state_e           sequencer FSM states
package spec_frame_sequencer_pkg;

    localparam int unsigned FftN    = 1024;
    localparam int unsigned Log2N   = 10;
    localparam int unsigned HalfN   = FftN / 2;
    localparam int unsigned GateW   = 6;
    localparam int unsigned PulseW  = 16;
    localparam int unsigned FifoCw  = 11;
    localparam int unsigned AddrW   = GateW + Log2N - 1;
    // One more bit than the gate count: a stalled FFT can leave every gate of a trigger in flight.
    localparam int unsigned FramesW = GateW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTrig,
        StWaitData,
        StFeed,
        StDrain,
        StFinish
    } seq_state_e;

endpackage

// File: rtl/spec_frame_sequencer_if.sv
// Datapath bus between the sequencer, the sample FIFO, the power-spectrum block and the
// accumulation RAM.
// Signals:
//   fifo_count  FIFO occupancy (words)
//   fifo_rd_en  FIFO read strobe
//   fft_start   FFT frame load strobe
//   spec_valid  power-spectrum bin valid
//   acc_addr    accumulator {gate, bin} address
//   acc_we      accumulator write enable
//   acc_first   write (not add) for the first pulse
// Modports: master = sequencer side, slave = datapath side.
interface spec_frame_sequencer_if;
    import spec_frame_sequencer_pkg::*;

    logic [FifoCw-1:0] fifo_count;
    logic              fifo_rd_en;
    logic              fft_start;
    logic              spec_valid;
    logic [AddrW-1:0]  acc_addr;
    logic              acc_we;
    logic              acc_first;

    modport master (
        input  fifo_count,
        input  spec_valid,
        output fifo_rd_en,
        output fft_start,
        output acc_addr,
        output acc_we,
        output acc_first
    );

    modport slave (
        output fifo_count,
        output spec_valid,
        input  fifo_rd_en,
        input  fft_start,
        input  acc_addr,
        input  acc_we,
        input  acc_first
    );

endinterface

// File: rtl/spec_frame_sequencer_bin_tagger.sv
// Tags returned power-spectrum bins with accumulator addresses, independent of the input FSM.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   arm_i             accepted arm: restart tagging, clear err_spec, mark pulse 0
//   abort_i           abort: restart tagging, drop frames in flight
//   frame_start_i     a frame has been committed to the FFT
//   spec_valid_i      bin valid from the power-spectrum block
//   gates_i           latched gates per trigger (>= 1)
//   acc_addr_o        {gate_out, bin_cnt}, valid with acc_we_o
//   acc_we_o          registered accepted spec_valid
//   acc_first_o       bin belongs to pulse 0
//   frames_idle_o     no frame outstanding
//   err_spec_o        sticky: spec_valid with no frame outstanding
module spec_frame_sequencer_bin_tagger
    import spec_frame_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             frame_start_i,
    input  logic             spec_valid_i,
    input  logic [GateW-1:0] gates_i,
    output logic [AddrW-1:0] acc_addr_o,
    output logic             acc_we_o,
    output logic             acc_first_o,
    output logic             frames_idle_o,
    output logic             err_spec_o
);

    logic [Log2N-2:0]   bin_cnt_q, bin_cnt_d;
    logic [GateW-1:0]   gate_out_q, gate_out_d;
    logic [FramesW-1:0] frames_out_q, frames_out_d;
    logic               first_q, first_d;
    logic               err_spec_q, err_spec_d;
    logic               acc_we_q, acc_we_d;
    logic               acc_first_q, acc_first_d;
    logic [AddrW-1:0]   acc_addr_q, acc_addr_d;
    logic               bin_ok;
    logic               last_bin;

    always_comb begin
        bin_cnt_d    = bin_cnt_q;
        gate_out_d   = gate_out_q;
        frames_out_d = frames_out_q;
        first_d      = first_q;
        err_spec_d   = err_spec_q;
        acc_addr_d   = acc_addr_q;
        acc_first_d  = acc_first_q;

        bin_ok   = spec_valid_i && (frames_out_q != '0);
        last_bin = bin_ok && (bin_cnt_q == '1);
        acc_we_d = bin_ok;

        if (bin_ok) begin
            acc_addr_d  = {gate_out_q, bin_cnt_q};
            acc_first_d = first_q;
            bin_cnt_d   = bin_cnt_q + 1'b1;  // wraps naturally at HalfN
        end

        if (spec_valid_i && (frames_out_q == '0)) begin
            err_spec_d = 1'b1;
        end

        // Frames leave in gate order, so a gate wrap marks the end of a pulse.
        if (last_bin) begin
            if (gate_out_q == gates_i - GateW'(1)) begin
                gate_out_d = '0;
                first_d    = 1'b0;
            end else begin
                gate_out_d = gate_out_q + GateW'(1);
            end
        end

        unique case ({frame_start_i, last_bin})
            2'b10:   frames_out_d = frames_out_q + FramesW'(1);
            2'b01:   frames_out_d = frames_out_q - FramesW'(1);
            default: frames_out_d = frames_out_q;
        endcase

        if (arm_i) begin
            bin_cnt_d    = '0;
            gate_out_d   = '0;
            frames_out_d = '0;
            first_d      = 1'b1;
            err_spec_d   = 1'b0;
        end
        if (abort_i) begin
            bin_cnt_d    = '0;
            gate_out_d   = '0;
            frames_out_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt_q    <= '0;
            gate_out_q   <= '0;
            frames_out_q <= '0;
            first_q      <= 1'b0;
            err_spec_q   <= 1'b0;
            acc_we_q     <= 1'b0;
            acc_first_q  <= 1'b0;
            acc_addr_q   <= '0;
        end else begin
            bin_cnt_q    <= bin_cnt_d;
            gate_out_q   <= gate_out_d;
            frames_out_q <= frames_out_d;
            first_q      <= first_d;
            err_spec_q   <= err_spec_d;
            acc_we_q     <= acc_we_d;
            acc_first_q  <= acc_first_d;
            acc_addr_q   <= acc_addr_d;
        end
    end

    assign acc_addr_o    = acc_addr_q;
    assign acc_we_o      = acc_we_q;
    assign acc_first_o   = acc_first_q;
    assign frames_idle_o = (frames_out_q == '0);
    assign err_spec_o    = err_spec_q;

endmodule

// File: rtl/spec_frame_sequencer.sv
// Sequences the 1024-point FFT power-spectrum datapath for one lidar acquisition: per trigger,
// cuts the sample FIFO into range-gate frames, feeds them to the FFT, and repeats per pulse.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   arm          start acquisition, latch cfg_* (IDLE only)
//   abort        return to IDLE next cycle, no done
//   cfg_gates    gates per trigger (0 -> 1)
//   cfg_pulses   triggers to accumulate (0 -> 1)
//   trig         laser trigger pulse
//   bus          FIFO / FFT / accumulator datapath (master side)
//   busy         not IDLE
//   done         one-cycle pulse after the last bin of the last pulse is written
//   err_trig     sticky: trig outside WAIT_TRIG
//   err_spec     sticky: spec_valid with no frame outstanding
module spec_frame_sequencer
    import spec_frame_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [GateW-1:0]       cfg_gates,
    input  logic [PulseW-1:0]      cfg_pulses,
    input  logic                   trig,
    spec_frame_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err_trig,
    output logic                   err_spec
);

    seq_state_e        state_q, state_d;
    logic [GateW-1:0]  gates_q, gates_d;
    logic [GateW-1:0]  gate_in_q, gate_in_d;
    logic [PulseW-1:0] pulses_q, pulses_d;
    logic [PulseW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [Log2N-1:0]  feed_cnt_q, feed_cnt_d;
    logic              err_trig_q, err_trig_d;
    logic              fft_start_q, fft_start_d;
    logic              arm_go;
    logic              frame_start;
    logic              frames_idle;
    logic              rd_en;

    always_comb begin
        state_d     = state_q;
        gates_d     = gates_q;
        gate_in_d   = gate_in_q;
        pulses_d    = pulses_q;
        pulse_cnt_d = pulse_cnt_q;
        feed_cnt_d  = feed_cnt_q;
        arm_go      = 1'b0;
        frame_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    arm_go      = 1'b1;
                    gates_d     = (cfg_gates == '0) ? GateW'(1) : cfg_gates;
                    pulses_d    = (cfg_pulses == '0) ? PulseW'(1) : cfg_pulses;
                    pulse_cnt_d = '0;
                    state_d     = StWaitTrig;
                end
            end
            StWaitTrig: begin
                if (trig) begin
                    gate_in_d = '0;
                    state_d   = StWaitData;
                end
            end
            StWaitData: begin
                // Commit the frame now; reads start on the next clock.
                if (bus.fifo_count >= FifoCw'(FftN)) begin
                    frame_start = 1'b1;
                    feed_cnt_d  = '0;
                    state_d     = StFeed;
                end
            end
            StFeed: begin
                feed_cnt_d = feed_cnt_q + 1'b1;
                if (feed_cnt_q == '1) begin
                    if (gate_in_q == gates_q - GateW'(1)) begin
                        state_d = StDrain;
                    end else begin
                        gate_in_d = gate_in_q + GateW'(1);
                        state_d   = StWaitData;
                    end
                end
            end
            StDrain: begin
                if (frames_idle) begin
                    if (pulse_cnt_q == pulses_q - PulseW'(1)) begin
                        state_d = StFinish;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PulseW'(1);
                        state_d     = StWaitTrig;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (abort) begin
            state_d     = StIdle;
            arm_go      = 1'b0;
            frame_start = 1'b0;
        end
    end

    always_comb begin
        err_trig_d = err_trig_q;
        if (arm_go) begin
            err_trig_d = 1'b0;
        end
        if (trig && (state_q != StWaitTrig)) begin
            err_trig_d = 1'b1;
        end
    end

    assign rd_en       = (state_q == StFeed);
    // Gated by abort so the FFT load strobe stops on the same clock as the FIFO reads.
    assign fft_start_d = rd_en && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gates_q     <= '0;
            gate_in_q   <= '0;
            pulses_q    <= '0;
            pulse_cnt_q <= '0;
            feed_cnt_q  <= '0;
            err_trig_q  <= 1'b0;
            fft_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gates_q     <= gates_d;
            gate_in_q   <= gate_in_d;
            pulses_q    <= pulses_d;
            pulse_cnt_q <= pulse_cnt_d;
            feed_cnt_q  <= feed_cnt_d;
            err_trig_q  <= err_trig_d;
            fft_start_q <= fft_start_d;
        end
    end

    logic [AddrW-1:0] acc_addr;
    logic             acc_we;
    logic             acc_first;

    spec_frame_sequencer_bin_tagger u_tagger (
        .clk           (clk),
        .rst           (rst),
        .arm_i         (arm_go),
        .abort_i       (abort),
        .frame_start_i (frame_start),
        .spec_valid_i  (bus.spec_valid),
        .gates_i       (gates_q),
        .acc_addr_o    (acc_addr),
        .acc_we_o      (acc_we),
        .acc_first_o   (acc_first),
        .frames_idle_o (frames_idle),
        .err_spec_o    (err_spec)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.fft_start  = fft_start_q;
    assign bus.acc_addr   = acc_addr;
    assign bus.acc_we     = acc_we;
    assign bus.acc_first  = acc_first;
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StFinish);
    assign err_trig       = err_trig_q;

endmodule

// File: tb/tb_spec_frame_sequencer.sv
// Randomized self-checking bench for spec_frame_sequencer. Models the sample FIFO, an FFT that
// returns HalfN bins per loaded frame, and the expected accumulator write stream.
module tb_spec_frame_sequencer;
    import spec_frame_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              abort;
    logic              trig;
    logic [GateW-1:0]  cfg_gates;
    logic [PulseW-1:0] cfg_pulses;
    logic              busy;
    logic              done;
    logic              err_trig;
    logic              err_spec;

    spec_frame_sequencer_if bus ();

    spec_frame_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .cfg_gates  (cfg_gates),
        .cfg_pulses (cfg_pulses),
        .trig       (trig),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err_trig   (err_trig),
        .err_spec   (err_spec)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Environment state
    int   fifo_level = 0;
    int   set_val = 0;
    logic set_req = 1'b0;
    int   prod_rate = 0;
    logic sv_fft = 1'b0;
    logic sv_inj = 1'b0;
    logic fft_kill = 1'b0;
    logic chk_burst = 1'b1;
    logic chk_fft = 1'b1;

    assign bus.fifo_count = fifo_level[FifoCw-1:0];
    assign bus.spec_valid = sv_fft | sv_inj;

    // Observations
    int rd_total = 0;
    int cur_burst = 0;
    int n_bursts = 0;
    int done_cnt = 0;
    int wr_idx = 0;
    logic prev_rd = 1'b0;
    logic [AddrW:0] exp_q[$];

    // Baselines per acquisition
    int rd_base, done_base, burst_base, wr_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic fifo_model();
        forever begin
            @(posedge clk);
            if (set_req) fifo_level <= set_val;
            else fifo_level <= fifo_level - (bus.fifo_rd_en ? 1 : 0)
                               + ((fifo_level < 2047 && $urandom_range(99, 0) < prod_rate) ? 1 : 0);
        end
    endtask

    // Every FftN load strobes make one frame; each frame returns HalfN bins with random gaps.
    task automatic fft_model();
        int load_cnt = 0;
        int pend = 0;
        int bins_left = 0;
        forever begin
            @(negedge clk);
            sv_fft = 1'b0;
            if (fft_kill) begin
                load_cnt = 0;
                pend = 0;
                bins_left = 0;
            end else begin
                if (bus.fft_start) begin
                    load_cnt++;
                    if (load_cnt == FftN) begin
                        load_cnt = 0;
                        pend++;
                    end
                end
                if (bins_left != 0) begin
                    if ($urandom_range(3, 0) != 0) begin
                        sv_fft = 1'b1;
                        bins_left--;
                    end
                end else if (pend != 0) begin
                    pend--;
                    bins_left = HalfN;
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (chk_fft && (prev_rd || bus.fft_start))
                    check("fft_start_lag", 32'(bus.fft_start), 32'(prev_rd));
                prev_rd = bus.fifo_rd_en;
                if (bus.fifo_rd_en) begin
                    rd_total++;
                    cur_burst++;
                end else if (cur_burst != 0) begin
                    if (chk_burst) check("burst_len", 32'(cur_burst), 32'(FftN));
                    n_bursts++;
                    cur_burst = 0;
                end
                if (done) done_cnt++;
                if (bus.acc_we) begin
                    if (wr_idx >= exp_q.size()) check("acc_unexpected", 32'(bus.acc_we), 32'(0));
                    else begin
                        check("acc_wr", 32'({bus.acc_first, bus.acc_addr}), 32'(exp_q[wr_idx]));
                        wr_idx++;
                    end
                end
            end
        end
    endtask

    task automatic set_fifo(input int v);
        set_val = v;
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    // Arm an acquisition; optionally push the write stream the specification predicts.
    task automatic start(input int g, input int p, input bit push);
        int eg, ep;
        eg = (g == 0) ? 1 : g;
        ep = (p == 0) ? 1 : p;
        wr_base = exp_q.size();
        if (push)
            for (int pi = 0; pi < ep; pi++)
                for (int gi = 0; gi < eg; gi++)
                    for (int b = 0; b < HalfN; b++)
                        exp_q.push_back({(pi == 0), GateW'(gi), (Log2N - 1)'(b)});
        rd_base = rd_total;
        done_base = done_cnt;
        burst_base = n_bursts;
        cfg_gates = GateW'(g);
        cfg_pulses = PulseW'(p);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("busy_arm", 32'(busy), 32'(1));
        check("err_clr_arm", 32'({err_trig, err_spec}), 32'(0));
    endtask

    task automatic finish_seq(input int eg, input int ep, input logic exp_et);
        for (int i = 0; i < eg * ep * 3000 + 3000; i++) begin
            if (done_cnt != done_base) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("done_cnt", 32'(done_cnt - done_base), 32'(1));
        check("rd_words", 32'(rd_total - rd_base), 32'(eg * ep * FftN));
        check("bursts", 32'(n_bursts - burst_base), 32'(eg * ep));
        check("writes_left", 32'(exp_q.size() - wr_idx), 32'(0));
        check("busy_end", 32'(busy), 32'(0));
        check("err_trig_end", 32'(err_trig), 32'(exp_et));
        check("err_spec_end", 32'(err_spec), 32'(0));
    endtask

    task automatic run_seq(input int g, input int p);
        int eg, ep;
        eg = (g == 0) ? 1 : g;
        ep = (p == 0) ? 1 : p;
        start(g, p, 1'b1);
        for (int pi = 0; pi < ep; pi++) begin
            for (int i = 0; i < eg * 3000 + 3000; i++) begin
                if (wr_idx >= wr_base + pi * eg * HalfN) break;
                @(negedge clk);
            end
            repeat (2 + $urandom_range(4, 0)) @(negedge clk);
            pulse_trig();
        end
        finish_seq(eg, ep, 1'b0);
    endtask

    initial begin : tb_main
        int k;
        int hold_rd, hold_idle;
        rst = 1'b1;
        arm = 1'b0;
        abort = 1'b0;
        trig = 1'b0;
        cfg_gates = '0;
        cfg_pulses = '0;
        fork
            fifo_model();
            fft_model();
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("rst_outs", 32'({bus.fifo_rd_en, bus.fft_start, bus.acc_we, bus.acc_first,
                               busy, done, err_trig, err_spec}), 32'(0));
        check("rst_addr", 32'(bus.acc_addr), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single gate, single pulse, FIFO preloaded with exactly one frame.
        prod_rate = 0;
        set_fifo(FftN);
        run_seq(1, 1);
        check("fifo_drained", 32'(fifo_level), 32'(0));

        // Three gates, two pulses.
        prod_rate = 100;
        run_seq(3, 2);

        // Randomized configurations including zero (treated as one).
        for (int it = 0; it < 3; it++) begin
            prod_rate = $urandom_range(100, 60);
            run_seq($urandom_range(3, 0), $urandom_range(2, 0));
        end

        // FIFO one word short of a frame: no reads until it fills.
        prod_rate = 0;
        set_fifo(FftN - 1);
        start(1, 1, 1'b1);
        pulse_trig();
        hold_rd = 0;
        hold_idle = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.fifo_rd_en) hold_rd++;
            if (!busy) hold_idle++;
        end
        check("hold_rd", 32'(hold_rd), 32'(0));
        check("hold_busy", 32'(hold_idle), 32'(0));
        set_fifo(FftN);
        finish_seq(1, 1, 1'b0);

        // Trigger during FEED: sticky error, acquisition still completes.
        prod_rate = 100;
        start(1, 1, 1'b1);
        pulse_trig();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) break;
        end
        repeat (20) @(negedge clk);
        pulse_trig();
        check("err_trig_set", 32'(err_trig), 32'(1));
        finish_seq(1, 1, 1'b1);

        // Stray spec_valid in IDLE.
        sv_inj = 1'b1;
        @(negedge clk);
        sv_inj = 1'b0;
        check("inj_acc_we", 32'(bus.acc_we), 32'(0));
        check("inj_err_spec", 32'(err_spec), 32'(1));
        @(negedge clk);

        // Abort mid-FEED at word 300.
        chk_burst = 1'b0;
        chk_fft = 1'b0;
        start(2, 1, 1'b0);
        pulse_trig();
        k = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) k++;
            if (k == 300) break;
        end
        abort = 1'b1;
        fft_kill = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_rd_en", 32'(bus.fifo_rd_en), 32'(0));
        check("abort_fft_start", 32'(bus.fft_start), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        repeat (5) @(negedge clk);
        fft_kill = 1'b0;
        check("abort_no_done", 32'(done_cnt - done_base), 32'(0));
        chk_burst = 1'b1;
        chk_fft = 1'b1;

        // Re-arm after abort: addresses restart at gate 0, bin 0.
        run_seq(1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
